// File: rtl/mmio_char_rx_pkg.sv
// Shared constants and helpers for the console-input peripheral:
// register offsets, status bit positions and the empty-read sentinel.
package mmio_char_rx_pkg;

  localparam logic [3:0] RXDATA_OFF = 4'h0;
  localparam logic [3:0] RXSTAT_OFF = 4'h4;
  localparam logic [3:0] RXCTRL_OFF = 4'h8;

  localparam int ST_NONEMPTY  = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_COUNT_LSB = 8;

  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_CLR_OVR = 1;

  localparam logic [31:0] RX_EMPTY_WORD = 32'h8000_0000;

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_STAT = 2'd1,
    REG_CTRL = 2'd2,
    REG_NONE = 2'd3
  } reg_sel_t;

  // Word select only; byte-lane bits of the address are ignored.
  function automatic reg_sel_t decode_reg(input logic [1:0] word);
    reg_sel_t sel;
    if (word == RXDATA_OFF[3:2])      sel = REG_DATA;
    else if (word == RXSTAT_OFF[3:2]) sel = REG_STAT;
    else if (word == RXCTRL_OFF[3:2]) sel = REG_CTRL;
    else                              sel = REG_NONE;
    return sel;
  endfunction

  function automatic logic [31:0] pack_status(input logic [7:0] count,
                                              input logic       overrun,
                                              input logic       full,
                                              input logic       nonempty);
    logic [31:0] word;
    word                             = '0;
    word[ST_COUNT_LSB +: 8]          = count;
    word[ST_OVERRUN]                 = overrun;
    word[ST_FULL]                    = full;
    word[ST_NONEMPTY]                = nonempty;
    return word;
  endfunction

endpackage

// File: rtl/mmio_char_rx_if.sv
// Data-bus slave port plus byte-source strobe and interrupt line of the
// console-input peripheral.
interface mmio_char_rx_if;
  logic        en_i;
  logic [3:0]  we_i;
  logic [3:0]  addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        irq_o;

  modport master (
    output en_i, we_i, addr_i, data_i, rx_valid_i, rx_data_i,
    input  data_o, irq_o
  );

  modport slave (
    input  en_i, we_i, addr_i, data_i, rx_valid_i, rx_data_i,
    output data_o, irq_o
  );
endinterface

// File: rtl/mmio_char_rx_sync_fifo.sv
// Single-clock FIFO with occupancy counter; pointers wrap naturally.
// A pop on a full FIFO frees the slot a same-cycle push lands in.
module sync_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_char_rx.sv
// Memory-mapped console input: bytes from a source are queued and read by the
// core over the data bus; raises a level interrupt while data is waiting.
module mmio_char_rx
  import mmio_char_rx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic reset,
  mmio_char_rx_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  reg_sel_t         sel;
  logic             rd_req;
  logic             wr_req;
  logic             ctrl_wr;
  logic             pop;
  logic             ovr_set;
  logic [7:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [7:0]       count8;
  logic [31:0]      rd_word;
  logic [31:0]      data_q;
  logic             irq_en;
  logic             overrun;
  logic             irq_q;
  logic             unused_bits;

  assign sel     = decode_reg(bus.addr_i[3:2]);
  assign rd_req  = bus.en_i && (bus.we_i == 4'b0000);
  assign wr_req  = bus.en_i && (bus.we_i != 4'b0000);
  assign ctrl_wr = wr_req && (sel == REG_CTRL) && bus.we_i[0];
  assign pop     = rd_req && (sel == REG_DATA) && !fifo_empty;
  // A dropped byte is only one that finds no free slot after a same-cycle pop.
  assign ovr_set = bus.rx_valid_i && fifo_full && !pop;
  assign count8  = 8'(fifo_count);

  assign unused_bits = ^{bus.data_i[31:2], bus.addr_i[1:0]};

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.rx_valid_i),
    .pop   (pop),
    .wdata (bus.rx_data_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    rd_word = '0;
    case (sel)
      REG_DATA: rd_word = fifo_empty ? RX_EMPTY_WORD : {24'b0, fifo_rdata};
      REG_STAT: rd_word = pack_status(count8, overrun, fifo_full, !fifo_empty);
      REG_CTRL: rd_word[CTRL_IRQ_EN] = irq_en;
      default:  rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      irq_en  <= 1'b0;
      overrun <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (rd_req)  data_q <= rd_word;
      if (ctrl_wr) irq_en <= bus.data_i[CTRL_IRQ_EN];
      // Set beats a coincident software clear.
      if (ovr_set)
        overrun <= 1'b1;
      else if (ctrl_wr && bus.data_i[CTRL_CLR_OVR])
        overrun <= 1'b0;
      irq_q <= irq_en && !fifo_empty;
    end
  end

  assign bus.data_o = data_q;
  assign bus.irq_o  = irq_q;

endmodule

// File: tb/tb_mmio_char_rx.sv
// Randomised and directed bench for mmio_char_rx: a queue-based reference model
// predicts read data into a scoreboard that a separate monitor drains.
module tb_mmio_char_rx;
  import mmio_char_rx_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mmio_char_rx_if bus ();

  mmio_char_rx #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_fifo [$];
  bit          m_ovr;
  bit          m_irq_en;
  logic [31:0] exp_q [$];
  bit          rd_fire;

  // Monitor: every registered read must match the oldest prediction.
  always @(posedge clk or posedge rst) begin
    if (rst) rd_fire <= 1'b0;
    else     rd_fire <= bus.en_i && (bus.we_i == 4'b0000);
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (rd_fire && !rst) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected: got data_o=%08h, no read predicted", bus.data_o);
      end else begin
        e = exp_q.pop_front();
        if (bus.data_o !== e) begin
          errors++;
          $display("FAIL read_data: got %08h, expected %08h", bus.data_o, e);
        end
      end
    end
  end

  // One bus/source cycle, issued at a negedge; model updated with the same rules.
  task automatic step(input bit rd, input bit wr, input logic [3:0] addr,
                      input logic [3:0] we, input logic [31:0] wd,
                      input bit rxv, input logic [7:0] rxd);
    logic [31:0] e;
    bit          exp_irq;
    int          n;
    bus.en_i       = rd | wr;
    bus.we_i       = wr ? we : 4'b0000;
    bus.addr_i     = addr;
    bus.data_i     = wd;
    bus.rx_valid_i = rxv;
    bus.rx_data_i  = rxd;
    exp_irq = m_irq_en && (m_fifo.size() > 0);
    if (rd) begin
      n = m_fifo.size();
      case (addr[3:2])
        2'd0: e = (n == 0) ? 32'h8000_0000 : {24'h0, m_fifo.pop_front()};
        2'd1: e = (n * 256) + (m_ovr ? 4 : 0) + ((n == DEPTH) ? 2 : 0) + ((n != 0) ? 1 : 0);
        2'd2: e = m_irq_en ? 32'd1 : 32'd0;
        default: e = 32'd0;
      endcase
      exp_q.push_back(e);
    end
    if (wr && we[0] && addr[3:2] == 2'd2) begin
      m_irq_en = wd[0];
      if (wd[1]) m_ovr = 1'b0;
    end
    if (rxv) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(rxd);
      else                       m_ovr = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (bus.irq_o !== exp_irq) begin
      errors++;
      $display("FAIL irq_level: got %0b, expected %0b", bus.irq_o, exp_irq);
    end
    bus.en_i       = 1'b0;
    bus.we_i       = 4'b0000;
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, b);
  endtask

  task automatic read_reg(input logic [3:0] addr);
    step(1'b1, 1'b0, addr, 4'h0, 32'h0, 1'b0, 8'h00);
  endtask

  task automatic write_ctrl(input logic [31:0] d);
    step(1'b0, 1'b1, RXCTRL_OFF, 4'hF, d, 1'b0, 8'h00);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 8'h00);
  endtask

  task automatic pulse_reset();
    #1;
    rst = 1'b1;
    m_fifo.delete();
    exp_q.delete();
    m_ovr    = 1'b0;
    m_irq_en = 1'b0;
    @(negedge clk);
    checks += 2;
    if (bus.data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_data_o: got %08h, expected 00000000", bus.data_o);
    end
    if (bus.irq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %0b, expected 0", bus.irq_o);
    end
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0]  b;
    logic [3:0]  a;
    logic [3:0]  w;
    int          op;
    bus.en_i = 1'b0; bus.we_i = 4'h0; bus.addr_i = 4'h0; bus.data_i = 32'h0;
    bus.rx_valid_i = 1'b0; bus.rx_data_i = 8'h00;
    m_ovr = 1'b0; m_irq_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset while data is queued
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    pulse_reset();
    read_reg(RXSTAT_OFF);
    read_reg(RXDATA_OFF);
    idle();

    // Basic read, interrupt disabled
    push_byte(8'h41); push_byte(8'h42);
    read_reg(RXSTAT_OFF);
    repeat (3) read_reg(RXDATA_OFF);

    // Fill, overflow, drain, clear overrun
    for (int i = 0; i <= DEPTH; i++) push_byte(8'(i));
    read_reg(RXSTAT_OFF);
    for (int i = 0; i < DEPTH; i++) read_reg(RXDATA_OFF);
    write_ctrl(32'h2);
    read_reg(RXSTAT_OFF);

    // Full with simultaneous pop and push
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h60 + i));
    step(1'b1, 1'b0, RXDATA_OFF, 4'h0, 32'h0, 1'b1, 8'hAA);
    read_reg(RXSTAT_OFF);
    for (int i = 0; i < DEPTH; i++) read_reg(RXDATA_OFF);
    read_reg(RXDATA_OFF);
    read_reg(RXSTAT_OFF);

    // Empty with simultaneous read and push: no bypass
    step(1'b1, 1'b0, RXDATA_OFF, 4'h0, 32'h0, 1'b1, 8'h5A);
    read_reg(RXSTAT_OFF);
    read_reg(RXDATA_OFF);

    // Interrupt
    write_ctrl(32'h1);
    idle();
    push_byte(8'h55);
    idle();
    read_reg(RXDATA_OFF);
    idle(); idle();
    read_reg(RXCTRL_OFF);
    read_reg(4'hC);

    // Wrap-around
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 5; i++) push_byte(8'($urandom));
      for (int i = 0; i < 5; i++) read_reg(RXDATA_OFF);
      read_reg(RXSTAT_OFF);
    end

    // Overrun clear coinciding with a dropped byte
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    step(1'b0, 1'b1, RXCTRL_OFF, 4'h1, 32'h2, 1'b1, 8'hEE);
    read_reg(RXSTAT_OFF);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      op = int'($urandom_range(0, 5));
      b  = 8'($urandom);
      a  = 4'($urandom);
      w  = 4'($urandom_range(1, 15));
      case (op)
        0, 1:    step(1'b1, 1'b0, {2'b00, a[1:0]}, 4'h0, 32'h0, $urandom_range(0, 1) == 1, b);
        2:       step(1'b1, 1'b0, a, 4'h0, 32'h0, $urandom_range(0, 2) != 0, b);
        3:       step(1'b0, 1'b1, ($urandom_range(0, 1) == 1) ? RXCTRL_OFF : a, w,
                      $urandom, $urandom_range(0, 1) == 1, b);
        default: step(1'b0, 1'b0, a, 4'h0, 32'h0, $urandom_range(0, 3) != 0, b);
      endcase
    end
    for (int i = 0; i <= DEPTH; i++) read_reg(RXDATA_OFF);
    read_reg(RXSTAT_OFF);

    repeat (3) idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d predicted reads never observed, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
